// File: rtl/microcontroller.sv
// Coin-operated washing-machine sequencer: one registered Moore FSM whose state code drives the actuator decoder.
// Build option CANCEL_DRAIN_EN: when defined, cancel in a running phase drains through SPIN instead of returning straight to IDLE.
module microcontroller #(
    parameter int RINSE_PASSES = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       sig_Lid_Closed,
    input  logic       sig_Coin,
    input  logic       sig_Cancel,
    input  logic       sig_Time_Out,
    input  logic       sig_Out_Of_Balance,
    input  logic       sig_Motor_Failure,
    output logic [2:0] state
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_READY   = 3'd1;
    localparam logic [2:0] S_SOAK    = 3'd2;
    localparam logic [2:0] S_WASH    = 3'd3;
    localparam logic [2:0] S_RINSE   = 3'd4;
    localparam logic [2:0] S_SPIN    = 3'd5;
    localparam logic [2:0] S_BALANCE = 3'd6;
    localparam logic [2:0] S_FAULT   = 3'd7;

    localparam logic [2:0] LAST_PASS = 3'(RINSE_PASSES - 1);

`ifdef CANCEL_DRAIN_EN
    localparam logic [2:0] CANCEL_TARGET = S_SPIN;
`else
    localparam logic [2:0] CANCEL_TARGET = S_IDLE;
`endif

    logic [2:0] r_state;
    logic [2:0] r_rinse_cnt;
    logic [2:0] w_next_state;
    logic [2:0] w_next_rinse_cnt;

    always_comb begin
        w_next_state     = r_state;
        w_next_rinse_cnt = r_rinse_cnt;
        case (r_state)
            S_IDLE: begin
                if (sig_Coin) w_next_state = S_READY;
            end
            S_READY: begin
                if (sig_Cancel) begin
                    w_next_state = S_IDLE;
                end else if (sig_Lid_Closed) begin
                    w_next_state     = S_SOAK;
                    w_next_rinse_cnt = 3'd0;
                end
            end
            S_SOAK, S_WASH, S_RINSE, S_SPIN: begin
                if (sig_Motor_Failure) begin
                    w_next_state = S_FAULT;
                end else if (sig_Cancel) begin
                    w_next_state = CANCEL_TARGET;
                end else if (!sig_Lid_Closed) begin
                    w_next_state = r_state;
                end else if ((r_state == S_SPIN) && sig_Out_Of_Balance) begin
                    w_next_state = S_BALANCE;
                end else if (sig_Time_Out) begin
                    // Phase advance; RINSE repeats until the pass counter reaches the last pass.
                    case (r_state)
                        S_SOAK: w_next_state = S_WASH;
                        S_WASH: w_next_state = S_RINSE;
                        S_RINSE: begin
                            if (r_rinse_cnt < LAST_PASS) w_next_rinse_cnt = r_rinse_cnt + 3'd1;
                            else                         w_next_state     = S_SPIN;
                        end
                        default: w_next_state = S_IDLE;
                    endcase
                end
            end
            S_BALANCE: begin
                if (sig_Motor_Failure) begin
                    w_next_state = S_FAULT;
                end else if (sig_Cancel) begin
                    w_next_state = S_IDLE;
                end else if (!sig_Out_Of_Balance && sig_Lid_Closed) begin
                    w_next_state = S_SPIN;
                end
            end
            default: w_next_state = S_FAULT;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_rinse_cnt <= 3'd0;
        end else begin
            r_state     <= w_next_state;
            r_rinse_cnt <= w_next_rinse_cnt;
        end
    end

    assign state = r_state;

endmodule

// File: tb/tb_microcontroller.sv
// Directed bench for the washing-machine sequencer (RINSE_PASSES = 2); the cancel-in-run checks follow CANCEL_DRAIN_EN.
module tb_microcontroller;

    logic       clock = 1'b0;
    logic       reset, sig_Lid_Closed, sig_Coin, sig_Cancel;
    logic       sig_Time_Out, sig_Out_Of_Balance, sig_Motor_Failure;
    logic [2:0] state;
    int         compared   = 0;
    int         mismatched = 0;

    microcontroller #(.RINSE_PASSES(2)) dut (
        .clock              (clock),
        .reset              (reset),
        .sig_Lid_Closed     (sig_Lid_Closed),
        .sig_Coin           (sig_Coin),
        .sig_Cancel         (sig_Cancel),
        .sig_Time_Out       (sig_Time_Out),
        .sig_Out_Of_Balance (sig_Out_Of_Balance),
        .sig_Motor_Failure  (sig_Motor_Failure),
        .state              (state)
    );

    always #5 clock = ~clock;

    // Drive one cycle of inputs, let the edge happen, sample 1 time unit later.
    task automatic apply(input logic rst, input logic coin, input logic lid, input logic cancel,
                         input logic tmo, input logic oob, input logic mot);
        reset              = rst;
        sig_Coin           = coin;
        sig_Lid_Closed     = lid;
        sig_Cancel         = cancel;
        sig_Time_Out       = tmo;
        sig_Out_Of_Balance = oob;
        sig_Motor_Failure  = mot;
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [2:0] exp);
        compared++;
        assert (state === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0d expected=%0d", tag, state, exp);
        end
    endtask

    localparam logic [2:0] CANCEL_RUN =
`ifdef CANCEL_DRAIN_EN
        3'd5;
`else
        3'd0;
`endif

    initial begin
        //        rst coin lid canc tmo oob mot
        apply(1, 0, 0, 0, 0, 0, 0); check("reset", 3'd0);
        for (int i = 0; i < 5; i++) begin
            apply(0, 0, 0, 0, 0, 0, 0); check("idle_hold", 3'd0);
        end
        apply(0, 0, 0, 0, 1, 0, 0); check("idle_timeout", 3'd0);
        apply(0, 0, 0, 0, 0, 0, 1); check("idle_motor", 3'd0);

        // Full cycle with two rinse passes, one Time_Out pulse per phase
        apply(0, 1, 0, 0, 0, 0, 0); check("coin", 3'd1);
        apply(0, 1, 0, 0, 0, 0, 0); check("ready_coin", 3'd1);
        apply(0, 0, 1, 0, 0, 0, 0); check("soak", 3'd2);
        apply(0, 0, 1, 0, 1, 0, 0); check("wash", 3'd3);
        apply(0, 0, 1, 0, 0, 0, 0); check("wash_hold", 3'd3);
        apply(0, 0, 1, 0, 1, 0, 0); check("rinse1", 3'd4);
        apply(0, 0, 1, 0, 0, 0, 0); check("rinse1_hold", 3'd4);
        apply(0, 0, 1, 0, 1, 0, 0); check("rinse2", 3'd4);
        apply(0, 0, 1, 0, 0, 0, 0); check("rinse2_hold", 3'd4);
        apply(0, 0, 1, 0, 1, 0, 0); check("spin", 3'd5);
        apply(0, 0, 1, 0, 0, 0, 0); check("spin_hold", 3'd5);
        apply(0, 0, 1, 0, 1, 0, 0); check("done", 3'd0);

        // Lid open in WASH blocks Time_Out
        apply(0, 1, 0, 0, 0, 0, 0); check("coin2", 3'd1);
        apply(0, 0, 1, 0, 0, 0, 0); check("soak2", 3'd2);
        apply(0, 0, 1, 0, 1, 0, 0); check("wash2", 3'd3);
        for (int i = 0; i < 3; i++) begin
            apply(0, 0, 0, 0, 1, 0, 0); check("lid_open_hold", 3'd3);
        end
        apply(0, 0, 1, 0, 1, 0, 0); check("lid_closed_rinse", 3'd4);
        apply(0, 0, 1, 0, 1, 0, 0); check("rinse_pass2", 3'd4);
        apply(0, 0, 1, 0, 1, 0, 0); check("spin2", 3'd5);

        // Imbalance: Out_Of_Balance beats simultaneous Time_Out
        apply(0, 0, 1, 0, 1, 1, 0); check("balance", 3'd6);
        apply(0, 0, 1, 0, 1, 1, 0); check("balance_hold", 3'd6);
        apply(0, 0, 0, 0, 0, 0, 0); check("balance_lid_open", 3'd6);
        apply(0, 0, 1, 0, 0, 0, 0); check("balance_clear", 3'd5);
        apply(0, 0, 1, 0, 1, 0, 0); check("spin_done", 3'd0);

        // Motor failure in RINSE is sticky until reset
        apply(0, 1, 0, 0, 0, 0, 0); check("coin3", 3'd1);
        apply(0, 0, 1, 0, 0, 0, 0); check("soak3", 3'd2);
        apply(0, 0, 1, 0, 1, 0, 0); check("wash3", 3'd3);
        apply(0, 0, 1, 0, 1, 0, 0); check("rinse3", 3'd4);
        apply(0, 0, 1, 1, 1, 0, 1); check("fault", 3'd7);
        apply(0, 0, 1, 1, 0, 0, 0); check("fault_cancel", 3'd7);
        apply(0, 1, 1, 0, 0, 0, 0); check("fault_coin", 3'd7);
        apply(0, 0, 1, 0, 1, 0, 0); check("fault_timeout", 3'd7);
        apply(1, 0, 1, 0, 0, 0, 0); check("fault_reset", 3'd0);

        // Cancel in SOAK
        apply(0, 1, 0, 0, 0, 0, 0); check("coin4", 3'd1);
        apply(0, 0, 1, 0, 0, 0, 0); check("soak4", 3'd2);
        apply(0, 0, 1, 1, 0, 0, 0); check("soak_cancel", CANCEL_RUN);
        apply(0, 0, 1, 0, 1, 0, 0); check("soak_cancel_after", 3'd0);

        // Coin+cancel in IDLE, then cancel in READY
        apply(0, 1, 0, 1, 0, 0, 0); check("coin_cancel_idle", 3'd1);
        apply(0, 0, 0, 1, 0, 0, 0); check("ready_cancel", 3'd0);

        // Time_Out with Cancel in WASH
        apply(0, 1, 0, 0, 0, 0, 0); check("coin5", 3'd1);
        apply(0, 0, 1, 0, 0, 0, 0); check("soak5", 3'd2);
        apply(0, 0, 1, 0, 1, 0, 0); check("wash5", 3'd3);
        apply(0, 0, 1, 1, 1, 0, 0); check("wash_cancel_tmo", CANCEL_RUN);

        // Cancel in BALANCE goes straight to IDLE
        apply(1, 0, 0, 0, 0, 0, 0); check("reset6", 3'd0);
        apply(0, 1, 0, 0, 0, 0, 0); check("coin6", 3'd1);
        apply(0, 0, 1, 0, 0, 0, 0); check("soak6", 3'd2);
        apply(0, 0, 1, 0, 1, 0, 0); check("wash6", 3'd3);
        apply(0, 0, 1, 0, 1, 0, 0); check("rinse6a", 3'd4);
        apply(0, 0, 1, 0, 1, 0, 0); check("rinse6b", 3'd4);
        apply(0, 0, 1, 0, 1, 0, 0); check("spin6", 3'd5);
        apply(0, 0, 1, 0, 0, 1, 0); check("balance6", 3'd6);
        apply(0, 0, 1, 1, 0, 1, 0); check("balance_cancel", 3'd0);

        // Reset mid-cycle
        apply(0, 1, 0, 0, 0, 0, 0); check("coin7", 3'd1);
        apply(0, 0, 1, 0, 0, 0, 0); check("soak7", 3'd2);
        apply(1, 0, 1, 0, 1, 0, 0); check("midcycle_reset", 3'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
